// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// It produces the per-register write enables and flushes from these inputs:
// load-use hazards, the multi-cycle divider, cache misses, mispredicts and exceptions.
// A redirect that arrives while the I-cache is busy is held until the I-cache can take it.
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_ReadRs,
  input  logic       ID_ReadRt,
  input  logic       EXE_IsLoad,
  input  logic [4:0] EXE_Dst,
  input  logic       EXE_IsDiv,
  input  logic       EXE_Mispredict,
  input  logic       MEM_ExcValid,
  input  logic       ICache_Busy,
  input  logic       DCache_Busy,
  output logic       PC_Wr,
  output logic       ID_Wr,
  output logic       EXE_Wr,
  output logic       MEM_Wr,
  output logic       WB_Wr,
  output logic       ID_Flush,
  output logic       EXE_Flush,
  output logic       MEM_Flush,
  output logic       WB_Flush,
  output logic       Redirect_Valid,
  output logic       Redirect_Sel,
  output logic       Div_Busy,
  output logic       Div_Done
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV      = 2'd1,
    DIV_DONE = 2'd2,
    REDIR    = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] div_cnt, div_cnt_nx;
  logic          pend_sel, pend_sel_nx;
  logic          load_use;

  // The ID instruction needs a register that a load in EXE has not produced yet.
  assign load_use = EXE_IsLoad && (EXE_Dst != 5'd0) &&
                    ((ID_ReadRs && (ID_rs == EXE_Dst)) ||
                     (ID_ReadRt && (ID_rt == EXE_Dst)));

  // This block holds the state register, the divider counter and the pending redirect select.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      div_cnt  <= '0;
      pend_sel <= 1'b0;
    end else begin
      state    <= state_nx;
      div_cnt  <= div_cnt_nx;
      pend_sel <= pend_sel_nx;
    end
  end

  // This block computes the next state and the stall/flush/redirect outputs.
  // The order of the branches sets the priority: exception, pending redirect, D-cache miss,
  // mispredict, divider, load-use, I-cache miss.
  always_comb begin
    state_nx       = state;
    div_cnt_nx     = div_cnt;
    pend_sel_nx    = pend_sel;
    PC_Wr          = 1'b1;
    ID_Wr          = 1'b1;
    EXE_Wr         = 1'b1;
    MEM_Wr         = 1'b1;
    WB_Wr          = 1'b1;
    ID_Flush       = 1'b0;
    EXE_Flush      = 1'b0;
    MEM_Flush      = 1'b0;
    WB_Flush       = 1'b0;
    Redirect_Valid = 1'b0;
    Redirect_Sel   = 1'b0;
    Div_Busy       = 1'b0;
    Div_Done       = 1'b0;

    if (rst) begin
      // While reset is held, freeze every register and keep every stage squashed.
      PC_Wr       = 1'b0;
      ID_Wr       = 1'b0;
      EXE_Wr      = 1'b0;
      MEM_Wr      = 1'b0;
      WB_Wr       = 1'b0;
      ID_Flush    = 1'b0 | 1'b1;
      EXE_Flush   = 1'b1;
      MEM_Flush   = 1'b1;
      WB_Flush    = 1'b1;
      state_nx    = RUN;
      div_cnt_nx  = '0;
      pend_sel_nx = 1'b0;
    end else if (MEM_ExcValid) begin
      // An exception squashes everything younger and aborts any divide in flight.
      ID_Flush     = 1'b1;
      EXE_Flush    = 1'b1;
      MEM_Flush    = 1'b1;
      WB_Flush     = 1'b1;
      Redirect_Sel = 1'b1;
      div_cnt_nx   = '0;
      if (!ICache_Busy) begin
        Redirect_Valid = 1'b1;
        state_nx       = RUN;
      end else begin
        PC_Wr       = 1'b0;
        pend_sel_nx = 1'b1;
        state_nx    = REDIR;
      end
    end else if (state == REDIR) begin
      // Keep bubbles flowing into ID until the I-cache frees up, then take the redirect.
      ID_Flush     = 1'b1;
      Redirect_Sel = pend_sel;
      if (ICache_Busy) begin
        PC_Wr = 1'b0;
      end else begin
        Redirect_Valid = 1'b1;
        state_nx       = RUN;
      end
      if (DCache_Busy) begin
        ID_Wr    = 1'b0;
        EXE_Wr   = 1'b0;
        MEM_Wr   = 1'b0;
        WB_Flush = 1'b1;
      end else begin
        WB_Flush = 1'b0;
      end
    end else begin
      // The divider keeps counting even while a D-cache miss freezes the pipe.
      case (state)
        DIV: begin
          Div_Busy = 1'b1;
          if (div_cnt == '0) begin
            state_nx = DIV_DONE;
          end else begin
            div_cnt_nx = div_cnt - 1'b1;
          end
        end
        DIV_DONE: begin
          Div_Done = 1'b1;
        end
        default: begin
          Div_Busy = 1'b0;
        end
      endcase

      if (DCache_Busy) begin
        PC_Wr    = 1'b0;
        ID_Wr    = 1'b0;
        EXE_Wr   = 1'b0;
        MEM_Wr   = 1'b0;
        WB_Flush = 1'b1;
        if ((state == RUN) && EXE_IsDiv) begin
          div_cnt_nx = DIV_LOAD;
          state_nx   = DIV;
        end else begin
          div_cnt_nx = div_cnt_nx;
        end
      end else if (EXE_Mispredict && (state != DIV)) begin
        // A mispredict squashes the ID instruction, so any load-use stall on it is moot.
        ID_Flush     = 1'b1;
        Redirect_Sel = 1'b0;
        if (!ICache_Busy) begin
          Redirect_Valid = 1'b1;
          state_nx       = RUN;
        end else begin
          PC_Wr       = 1'b0;
          pend_sel_nx = 1'b0;
          state_nx    = REDIR;
        end
      end else if (state == DIV) begin
        PC_Wr     = 1'b0;
        ID_Wr     = 1'b0;
        EXE_Wr    = 1'b0;
        MEM_Flush = 1'b1;
      end else begin
        if (load_use) begin
          PC_Wr     = 1'b0;
          ID_Wr     = 1'b0;
          EXE_Flush = 1'b1;
        end else if (ICache_Busy) begin
          PC_Wr    = 1'b0;
          ID_Flush = 1'b1;
        end else begin
          ID_Flush = 1'b0;
        end
        // EXE advances here, so a finished divide leaves DIV_DONE and cannot re-trigger.
        if (state == DIV_DONE) begin
          state_nx = RUN;
        end else if (EXE_IsDiv) begin
          div_cnt_nx = DIV_LOAD;
          state_nx   = DIV;
        end else begin
          state_nx = RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Directed scenarios plus randomized traffic
// are compared each cycle against a stage-depth reference model.
module tb_pipe_hazard_ctrl;

  localparam int DIV_CYCLES = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ID_rs, ID_rt, EXE_Dst;
  logic       ID_ReadRs, ID_ReadRt, EXE_IsLoad, EXE_IsDiv, EXE_Mispredict;
  logic       MEM_ExcValid, ICache_Busy, DCache_Busy;
  logic       PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr;
  logic       ID_Flush, EXE_Flush, MEM_Flush, WB_Flush;
  logic       Redirect_Valid, Redirect_Sel, Div_Busy, Div_Done;

  int checks   = 0;
  int failures = 0;

  // Reference model state: remaining divide cycles, result-ready flag, pending redirect.
  int m_div_left;
  bit m_done;
  bit m_pend;
  bit m_psel;

  int busy_count;

  pipe_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_ReadRs(ID_ReadRs), .ID_ReadRt(ID_ReadRt),
    .EXE_IsLoad(EXE_IsLoad), .EXE_Dst(EXE_Dst), .EXE_IsDiv(EXE_IsDiv),
    .EXE_Mispredict(EXE_Mispredict), .MEM_ExcValid(MEM_ExcValid),
    .ICache_Busy(ICache_Busy), .DCache_Busy(DCache_Busy),
    .PC_Wr(PC_Wr), .ID_Wr(ID_Wr), .EXE_Wr(EXE_Wr), .MEM_Wr(MEM_Wr), .WB_Wr(WB_Wr),
    .ID_Flush(ID_Flush), .EXE_Flush(EXE_Flush), .MEM_Flush(MEM_Flush), .WB_Flush(WB_Flush),
    .Redirect_Valid(Redirect_Valid), .Redirect_Sel(Redirect_Sel),
    .Div_Busy(Div_Busy), .Div_Done(Div_Done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 1'b0; ID_rs = 5'd0; ID_rt = 5'd0; ID_ReadRs = 1'b0; ID_ReadRt = 1'b0;
    EXE_IsLoad = 1'b0; EXE_Dst = 5'd0; EXE_IsDiv = 1'b0; EXE_Mispredict = 1'b0;
    MEM_ExcValid = 1'b0; ICache_Busy = 1'b0; DCache_Busy = 1'b0;
  endtask

  // One cycle: sample at the falling edge, compare, advance the model, return after the next rise.
  task automatic cycle();
    bit wr[5];
    bit fl[5];
    bit rv, sel, busy, done, lu, extra_id;
    int held;
    @(negedge clk);
    rv = 1'b0; sel = 1'b0; busy = 1'b0; done = 1'b0; extra_id = 1'b0; held = 0;
    lu = EXE_IsLoad && (EXE_Dst != 5'd0) &&
         ((ID_ReadRs && ID_rs == EXE_Dst) || (ID_ReadRt && ID_rt == EXE_Dst));
    for (int i = 0; i < 5; i++) begin wr[i] = 1'b0; fl[i] = 1'b0; end
    if (rst) begin
      for (int i = 1; i < 5; i++) fl[i] = 1'b1;
    end else if (MEM_ExcValid) begin
      for (int i = 0; i < 5; i++) wr[i] = 1'b1;
      for (int i = 1; i < 5; i++) fl[i] = 1'b1;
      wr[0] = !ICache_Busy;
      rv = !ICache_Busy;
      sel = 1'b1;
    end else begin
      busy = (m_div_left > 0);
      done = m_done;
      if (m_pend) begin
        extra_id = 1'b1;
        sel = m_psel;
        if (ICache_Busy) held = 1; else rv = 1'b1;
        if (DCache_Busy) held = 4;
      end else if (DCache_Busy) begin
        held = 4;
      end else if (EXE_Mispredict && !busy) begin
        extra_id = 1'b1;
        if (ICache_Busy) held = 1; else rv = 1'b1;
      end else begin
        if (ICache_Busy) held = 1;
        if (lu) held = 2;
        if (busy) held = 3;
      end
      // Stages upstream of the deepest held stage keep their contents; the next one gets a bubble.
      for (int i = 0; i < 5; i++) begin
        wr[i] = (i >= held);
        fl[i] = (held > 0) && (i == held);
      end
      if (rv) wr[0] = 1'b1;
      if (extra_id) fl[1] = 1'b1;
    end
    check("wr", {11'd0, PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr},
                {11'd0, wr[0], wr[1], wr[2], wr[3], wr[4]});
    check("flush", {12'd0, ID_Flush, EXE_Flush, MEM_Flush, WB_Flush},
                   {12'd0, fl[1], fl[2], fl[3], fl[4]});
    check("redir_div", {12'd0, Redirect_Valid, Redirect_Sel, Div_Busy, Div_Done},
                       {12'd0, rv, sel, busy, done});
    if (Div_Busy) busy_count++;
    // Advance the model with this cycle's inputs.
    if (rst) begin
      m_div_left = 0; m_done = 1'b0; m_pend = 1'b0; m_psel = 1'b0;
    end else if (MEM_ExcValid) begin
      m_div_left = 0; m_done = 1'b0; m_pend = ICache_Busy; m_psel = 1'b1;
    end else if (m_pend) begin
      if (!ICache_Busy) m_pend = 1'b0;
    end else if (m_div_left > 0) begin
      m_div_left--;
      if (m_div_left == 0) m_done = 1'b1;
    end else if (DCache_Busy) begin
      if (!m_done && EXE_IsDiv) m_div_left = DIV_CYCLES;
    end else if (EXE_Mispredict) begin
      m_done = 1'b0;
      if (ICache_Busy) begin m_pend = 1'b1; m_psel = 1'b0; end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (EXE_IsDiv) begin
      m_div_left = DIV_CYCLES;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_div_left = 0; m_done = 1'b0; m_pend = 1'b0; m_psel = 1'b0;
    busy_count = 0;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // Load-use on rs, then the same with r0 as the destination.
    EXE_IsLoad = 1'b1; EXE_Dst = 5'd5; ID_rs = 5'd5; ID_ReadRs = 1'b1;
    cycle();
    EXE_Dst = 5'd0; ID_rs = 5'd0;
    cycle();
    idle(); EXE_IsLoad = 1'b1; EXE_Dst = 5'd7; ID_rt = 5'd7; ID_ReadRt = 1'b1;
    cycle();
    idle(); cycle();

    // Full divide with a D-cache pulse during the result-ready phase.
    busy_count = 0;
    EXE_IsDiv = 1'b1;
    repeat (DIV_CYCLES + 1) cycle();
    DCache_Busy = 1'b1;
    cycle();
    DCache_Busy = 1'b0;
    cycle();
    EXE_IsDiv = 1'b0;
    check("div_len", 16'(busy_count), 16'(DIV_CYCLES));
    repeat (2) cycle();

    // Exception ten cycles into a divide.
    EXE_IsDiv = 1'b1;
    repeat (11) cycle();
    EXE_IsDiv = 1'b0; MEM_ExcValid = 1'b1;
    cycle();
    MEM_ExcValid = 1'b0;
    repeat (2) cycle();

    // Mispredict while the I-cache is busy for three cycles.
    EXE_Mispredict = 1'b1; ICache_Busy = 1'b1;
    cycle();
    EXE_Mispredict = 1'b0;
    repeat (2) cycle();
    ICache_Busy = 1'b0;
    repeat (2) cycle();

    // Exception, mispredict and load-use together.
    MEM_ExcValid = 1'b1; EXE_Mispredict = 1'b1;
    EXE_IsLoad = 1'b1; EXE_Dst = 5'd9; ID_rs = 5'd9; ID_ReadRs = 1'b1;
    cycle();
    idle(); cycle();

    // Reset in the middle of a divide.
    EXE_IsDiv = 1'b1;
    repeat (5) cycle();
    EXE_IsDiv = 1'b0; rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      rst            = ($urandom_range(0, 299) == 0);
      MEM_ExcValid   = ($urandom_range(0, 39) == 0);
      EXE_Mispredict = ($urandom_range(0, 11) == 0);
      ICache_Busy    = ($urandom_range(0, 4) == 0);
      DCache_Busy    = ($urandom_range(0, 5) == 0);
      EXE_IsDiv      = ($urandom_range(0, 19) == 0);
      EXE_IsLoad     = ($urandom_range(0, 2) == 0);
      EXE_Dst        = 5'($urandom_range(0, 3));
      ID_rs          = 5'($urandom_range(0, 3));
      ID_rt          = 5'($urandom_range(0, 3));
      ID_ReadRs      = 1'($urandom_range(0, 1));
      ID_ReadRt      = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the five-stage pipeline.
- Each cycle it generates the write enable (*_Wr) and flush (*_Flush) for the PC, ID, EXE, MEM and WB pipeline registers. Inputs are load-use hazards, the multi-cycle divider, I/D-cache misses, branch mispredicts and exceptions.
- It sequences the divider occupancy and holds pending PC redirects until the I-cache can accept them.

Parameters:
- DIV_CYCLES, 32: EXE-stage stall cycles for DIV/DIVU (counter width = clog2(DIV_CYCLES)).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ID_rs  in  5  source reg rs of ID instr
- ID_rt  in  5  source reg rt of ID instr
- ID_ReadRs  in  1  ID instr reads rs
- ID_ReadRt  in  1  ID instr reads rt
- EXE_IsLoad  in  1  EXE instr is load or MFC0
- EXE_Dst  in  5  EXE destination register
- EXE_IsDiv  in  1  EXE holds DIV/DIVU (level, held while in EXE)
- EXE_Mispredict  in  1  EXE resolved branch/jump mispredicted
- MEM_ExcValid  in  1  exception/ERET committed in MEM
- ICache_Busy  in  1  I-cache miss in progress
- DCache_Busy  in  1  D-cache miss in progress
- PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr  out  1 each  register write enables
- ID_Flush, EXE_Flush, MEM_Flush, WB_Flush  out  1 each  register flushes (flush overrides Wr in the register)
- Redirect_Valid  out  1  PC must load redirect target this cycle
- Redirect_Sel  out  1  0 = branch target, 1 = exception vector
- Div_Busy  out  1  divider counting
- Div_Done  out  1  divider result valid in EXE

Behaviour:
- FSM states:
  - RUN
  - DIV: counter active
  - DIV_DONE: result valid, waiting for EXE to advance
  - REDIR: redirect pending because the I-cache is busy
- Counter div_cnt; pending registers pend_sel.
- Reset (rst=1 at clk edge):
  - State RUN, div_cnt=0, pend cleared.
  - While rst is high, all *_Wr=0, all *_Flush=1, Redirect_Valid=0, Div_Busy=0, Div_Done=0.
- Outputs are combinational from state plus inputs. Default: all Wr=1, all Flush=0. Priority per cycle, highest first:
  1. MEM_ExcValid:
     - ID_Flush=EXE_Flush=MEM_Flush=WB_Flush=1, Redirect_Sel=1.
     - If !ICache_Busy: Redirect_Valid=1, PC_Wr=1. Else PC_Wr=0, pend_sel<=1, go REDIR.
     - Aborts DIV/DIV_DONE: div_cnt<=0.
  2. State REDIR:
     - ID_Flush=1, PC_Wr=0 while ICache_Busy.
     - First cycle with !ICache_Busy: Redirect_Valid=1, Redirect_Sel=pend_sel, PC_Wr=1, go RUN.
     - DCache_Busy stalls still apply to EXE/MEM in REDIR.
  3. DCache_Busy: PC_Wr=ID_Wr=EXE_Wr=MEM_Wr=0, WB_Flush=1. The FSM holds (div_cnt still decrements in DIV).
  4. EXE_Mispredict (state RUN or DIV_DONE):
     - ID_Flush=1, Redirect_Sel=0.
     - If !ICache_Busy: Redirect_Valid=1. Else PC_Wr=0, pend_sel<=0, go REDIR.
     - Overrides load-use (the ID instr is squashed).
  5. Divider:
     - In RUN with EXE_IsDiv=1: div_cnt<=DIV_CYCLES-1, go DIV.
     - In DIV: PC_Wr=ID_Wr=EXE_Wr=0, MEM_Flush=1, Div_Busy=1, div_cnt decrements. At div_cnt==0, go DIV_DONE (the stall is still asserted that cycle).
     - In DIV_DONE: Div_Done=1, no div stall. Return to RUN when EXE_Wr=1 (EXE advances). Never re-trigger on the same instr.
  6. Load-use: EXE_IsLoad && EXE_Dst!=0 && ((ID_ReadRs && ID_rs==EXE_Dst) || (ID_ReadRt && ID_rt==EXE_Dst)) gives PC_Wr=ID_Wr=0, EXE_Flush=1.
  7. ICache_Busy: PC_Wr=0, ID_Flush=1 (bubble into ID).
- Combined stalls: PC_Wr and ID_Wr are the AND of all applicable conditions. Flushes are applied only to the stage just downstream of the deepest stalled stage.
- RUN with EXE_IsDiv=1 and DCache_Busy=1: the DIV entry still occurs. Total EXE occupancy is DIV_CYCLES plus the DIV_DONE residency.
- Reset mid-DIV or mid-REDIR returns to RUN with the counter cleared. No redirect is emitted.

Test Plan:
- Load-use: EXE_IsLoad=1, EXE_Dst=5, ID_rs=5, ID_ReadRs=1 -> one cycle PC_Wr=ID_Wr=0, EXE_Flush=1. With EXE_Dst=0 -> no stall.
- Divide: EXE_IsDiv=1 in RUN, DIV_CYCLES=32 -> EXE_Wr=0, MEM_Flush=1 for 32 cycles, Div_Busy for 32 cycles, then Div_Done=1 and EXE_Wr=1. A DCache_Busy pulse during DIV_DONE holds Div_Done with no restart.
- Exception during DIV (cycle 10): MEM_ExcValid=1 -> ID/EXE/MEM/WB_Flush=1, Redirect_Valid=1, Redirect_Sel=1; the next cycle is RUN with Div_Busy=0.
- Mispredict with ICache_Busy high 3 cycles -> PC_Wr=0 and ID_Flush=1 for 3 cycles, then Redirect_Valid=1, Redirect_Sel=0 for exactly one cycle.
- Simultaneous MEM_ExcValid, EXE_Mispredict and load-use -> Redirect_Sel=1, all four flushes asserted, load-use suppressed.
- Reset: rst=1 in DIV -> all Wr=0, all Flush=1. After release the state is RUN, Div_Busy=0 and all Wr=1.
